pipeline_controller: RTL and testbench
======================================

# pipeline_controller

Sequences the five-stage LC-3b pipeline around the forwarding datapath. Generates per-stage pipeline-register load and flush controls from memory handshakes, load-use hazards, taken branches, and the two-access LDI/STI sequence. Latches early memory responses so that no data is lost during a freeze. Keeps saturating stall, bubble and flush counters for performance debug.

## Interface
- No parameters. Register specifiers are `lc3b_reg` (3 bits). Counters are 16 bits.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `imem_resp` in 1: instruction memory response; a one-cycle pulse.
- `mem_access` in 1: the MEM-stage instruction accesses data memory.
- `mem_indirect` in 1: the MEM-stage instruction is LDI or STI.
- `dmem_resp` in 1: data memory response; a one-cycle pulse.
- `br_taken` in 1: branch/jump taken, resolved in MEM.
- `ex_load_inst`, `ex_regfile_write` in 1 each: the EX-stage instruction is a load that writes the register file.
- `ex_dest` in `lc3b_reg`: EX-stage destination register.
- `id_uses_sr1`, `id_uses_sr2` in 1 each: the ID-stage instruction reads SR1 / SR2.
- `id_sr1`, `id_sr2` in `lc3b_reg`: ID-stage source registers.
- `perf_clear` in 1: synchronous clear of the counters.
- `imem_req`, `dmem_req` out 1 each: memory request strobes.
- `load_ir`, `load_mdr` out 1 each: capture the fetched word / the data-memory word.
- `load_pc`, `pc_sel` out 1 each: update PC; `pc_sel` 1 selects the branch target.
- `load_if_id`, `load_id_ex`, `load_ex_mem`, `load_mem_wb` out 1 each: pipeline register loads.
- `flush_if_id`, `flush_id_ex`, `flush_ex_mem` out 1 each: load a bubble instead of data. Each is meaningful only together with the matching load signal.
- `indirect_sel` out 1: 1 means the MEM address comes from MDR (second indirect access).
- `stall_count`, `bubble_count`, `flush_count` out 16 each: saturating counters.

## Operation
- State: FSM {RUN, IND2}, plus sticky flags `imem_done` and `dmem_done`.
- Derived terms:
  - `imem_ok = imem_done | imem_resp`
  - `dmem_ok = !mem_access | dmem_done | dmem_resp`
  - `phase1 = (state==RUN) & mem_indirect & mem_access & (dmem_done | dmem_resp)`
  - `advance = imem_ok & dmem_ok & !phase1`
  - `lu_hazard = ex_load_inst & ex_regfile_write & ((id_uses_sr1 & ex_dest==id_sr1) | (id_uses_sr2 & ex_dest==id_sr2))`
- Request and latch outputs:
  - `imem_req = !imem_done`
  - `dmem_req = mem_access & !dmem_done`
  - `load_ir = imem_resp & !imem_done`
  - `load_mdr = dmem_resp & mem_access & !dmem_done`
  - `indirect_sel = (state==IND2)`
- `!advance` (freeze): every `load_*`, `flush_*` and `pc_sel` is 0.
  - `imem_done` is set by `imem_resp`.
  - `dmem_done` is set by `load_mdr`.
  - On `phase1`: next state is IND2 and `dmem_done` is cleared, so the second access issues the next cycle.
- `advance` with `br_taken` (highest priority):
  - `load_pc=1`, `pc_sel=1`, all four register loads = 1.
  - `flush_if_id`, `flush_id_ex`, `flush_ex_mem` = 1.
  - `lu_hazard` is ignored.
- `advance` with `lu_hazard` and no branch:
  - `load_pc=0`, `load_if_id=0`.
  - `load_id_ex=1` with `flush_id_ex=1`; `load_ex_mem=1`, `load_mem_wb=1`.
  - `imem_done` is kept, so IR is held and not refetched.
- Plain `advance`: all loads = 1, no flushes.
- On every advance:
  - `dmem_done` is cleared.
  - `imem_done` is cleared when `load_pc`.
  - IND2 returns to RUN.
- Counters: each saturates at 16'hFFFF. `perf_clear` has priority over increment.
  - `stall_count` increments on each `!advance` cycle.
  - `bubble_count` increments on each load-use bubble.
  - `flush_count` increments on each branch flush.

## Timing
- While `reset_n` is low:
  - State is RUN; flags and counters are 0.
  - All `load_*`, `flush_*`, `pc_sel`, `load_ir`, `load_mdr` and `indirect_sel` are 0.
  - `imem_req` and `dmem_req` are 0.
- Reset asserted mid-access abandons the access. After release, `imem_req=1` in the first cycle.
- All control outputs are combinational from inputs and state, with zero-cycle latency.
- Load-use costs exactly 1 bubble.
- LDI/STI costs at least 1 freeze cycle (the `phase1` cycle) plus the second-access latency.
- Simultaneous `imem_resp` and `dmem_resp`: advance in that cycle, and both latch strobes fire.
- A response arriving during a freeze is latched once. No re-request is issued until the pipeline advances.
- `br_taken` and `lu_hazard` are acted on only in the advance cycle.

## Test plan
- Reset release, `imem_resp` in cycle 2, no `mem_access` → `imem_req=1` in cycles 1-2; all loads = 1 in cycle 2; `stall_count=1`.
- `ex_load_inst=1`, `ex_regfile_write=1`, `ex_dest=3`, `id_uses_sr2=1`, `id_sr2=3`, `imem_done` set → `load_pc=0`, `load_if_id=0`, `load_id_ex=1`, `flush_id_ex=1`; `bubble_count` goes 0→1.
- LDI: `mem_access=1`, `mem_indirect=1`, `dmem_resp` at cycle 3 and again at cycle 6 → freeze through cycle 5; `indirect_sel=1` in cycles 4-6; advance in cycle 6; `load_mdr` in cycles 3 and 6.
- `dmem_resp` in cycle 2 while `imem_resp` is withheld until cycle 5 → `load_mdr` only in cycle 2; `dmem_req=0` in cycles 3-5; advance in cycle 5.
- `br_taken=1` together with `lu_hazard=1` on an advance → `pc_sel=1`, three flushes, `flush_count=1`, `bubble_count` unchanged.
- 70000 forced stall cycles, then `perf_clear` → `stall_count` holds 16'hFFFF, then reads 0 the cycle after the clear.

Source files
------------

// File: rtl/pipeline_controller_if.sv
// Control bundle between the LC-3b pipeline datapath and its controller.
// master: controller side (drives loads/flushes/requests/counters); slave: datapath side.
interface pipeline_controller_if;
    typedef logic [2:0] lc3b_reg;

    logic        imem_resp;
    logic        mem_access;
    logic        mem_indirect;
    logic        dmem_resp;
    logic        br_taken;
    logic        ex_load_inst;
    logic        ex_regfile_write;
    lc3b_reg     ex_dest;
    logic        id_uses_sr1;
    logic        id_uses_sr2;
    lc3b_reg     id_sr1;
    lc3b_reg     id_sr2;
    logic        perf_clear;

    logic        imem_req;
    logic        dmem_req;
    logic        load_ir;
    logic        load_mdr;
    logic        load_pc;
    logic        pc_sel;
    logic        load_if_id;
    logic        load_id_ex;
    logic        load_ex_mem;
    logic        load_mem_wb;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        flush_ex_mem;
    logic        indirect_sel;
    logic [15:0] stall_count;
    logic [15:0] bubble_count;
    logic [15:0] flush_count;

    modport master (
        input  imem_resp, mem_access, mem_indirect, dmem_resp, br_taken,
               ex_load_inst, ex_regfile_write, ex_dest,
               id_uses_sr1, id_uses_sr2, id_sr1, id_sr2, perf_clear,
        output imem_req, dmem_req, load_ir, load_mdr, load_pc, pc_sel,
               load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               flush_if_id, flush_id_ex, flush_ex_mem, indirect_sel,
               stall_count, bubble_count, flush_count
    );

    modport slave (
        output imem_resp, mem_access, mem_indirect, dmem_resp, br_taken,
               ex_load_inst, ex_regfile_write, ex_dest,
               id_uses_sr1, id_uses_sr2, id_sr1, id_sr2, perf_clear,
        input  imem_req, dmem_req, load_ir, load_mdr, load_pc, pc_sel,
               load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               flush_if_id, flush_id_ex, flush_ex_mem, indirect_sel,
               stall_count, bubble_count, flush_count
    );
endinterface

// File: rtl/pipeline_controller.sv
// LC-3b five-stage pipeline controller: stage loads/flushes, LDI/STI sequencing,
// early-response latching, saturating perf counters. Ports: clk, reset_n, bus (master).
module pipeline_controller (
    input  logic                  clk,
    input  logic                  reset_n,
    pipeline_controller_if.master bus
);
    typedef enum logic {RUN = 1'b0, IND2 = 1'b1} state_e;

    state_e      state_q, state_d;
    logic        imem_done_q, imem_done_d;
    logic        dmem_done_q, dmem_done_d;
    logic [15:0] stall_q, bubble_q, flush_q;

    logic imem_ok, dmem_ok, phase1, advance, lu_hazard;
    logic bubble_ev, flush_ev;

    assign imem_ok = imem_done_q | bus.imem_resp;
    assign dmem_ok = !bus.mem_access | dmem_done_q | bus.dmem_resp;
    // First half of LDI/STI: pointer word arrived, freeze and reissue
    assign phase1 = (state_q == RUN) & bus.mem_indirect & bus.mem_access
                  & (dmem_done_q | bus.dmem_resp);
    assign advance = imem_ok & dmem_ok & !phase1;
    assign lu_hazard = bus.ex_load_inst & bus.ex_regfile_write
        & ((bus.id_uses_sr1 & (bus.ex_dest == bus.id_sr1))
         | (bus.id_uses_sr2 & (bus.ex_dest == bus.id_sr2)));

    assign bubble_ev = advance & !bus.br_taken & lu_hazard;
    assign flush_ev  = advance & bus.br_taken;

    always_comb begin
        state_d          = state_q;
        imem_done_d      = imem_done_q;
        dmem_done_d      = dmem_done_q;
        bus.imem_req     = 1'b0;
        bus.dmem_req     = 1'b0;
        bus.load_ir      = 1'b0;
        bus.load_mdr     = 1'b0;
        bus.load_pc      = 1'b0;
        bus.pc_sel       = 1'b0;
        bus.load_if_id   = 1'b0;
        bus.load_id_ex   = 1'b0;
        bus.load_ex_mem  = 1'b0;
        bus.load_mem_wb  = 1'b0;
        bus.flush_if_id  = 1'b0;
        bus.flush_id_ex  = 1'b0;
        bus.flush_ex_mem = 1'b0;
        bus.indirect_sel = 1'b0;
        // Outputs are forced quiet while reset is held
        if (reset_n) begin
            bus.imem_req     = !imem_done_q;
            bus.dmem_req     = bus.mem_access & !dmem_done_q;
            bus.load_ir      = bus.imem_resp & !imem_done_q;
            bus.load_mdr     = bus.dmem_resp & bus.mem_access & !dmem_done_q;
            bus.indirect_sel = (state_q == IND2);
            if (!advance) begin
                if (bus.imem_resp) imem_done_d = 1'b1;
                if (bus.load_mdr)  dmem_done_d = 1'b1;
                if (phase1) begin
                    state_d     = IND2;
                    dmem_done_d = 1'b0;
                end
            end else begin
                bus.load_id_ex  = 1'b1;
                bus.load_ex_mem = 1'b1;
                bus.load_mem_wb = 1'b1;
                if (bus.br_taken) begin
                    bus.load_pc      = 1'b1;
                    bus.pc_sel       = 1'b1;
                    bus.load_if_id   = 1'b1;
                    bus.flush_if_id  = 1'b1;
                    bus.flush_id_ex  = 1'b1;
                    bus.flush_ex_mem = 1'b1;
                end else if (lu_hazard) begin
                    bus.flush_id_ex = 1'b1;
                end else begin
                    bus.load_pc    = 1'b1;
                    bus.load_if_id = 1'b1;
                end
                dmem_done_d = 1'b0;
                // Held IR (bubble) keeps its fetch marked done
                imem_done_d = bus.load_pc ? 1'b0 : imem_ok;
                state_d     = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN;
            imem_done_q <= 1'b0;
            dmem_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            imem_done_q <= imem_done_d;
            dmem_done_q <= dmem_done_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q  <= 16'h0000;
            bubble_q <= 16'h0000;
            flush_q  <= 16'h0000;
        end else if (bus.perf_clear) begin
            stall_q  <= 16'h0000;
            bubble_q <= 16'h0000;
            flush_q  <= 16'h0000;
        end else begin
            if (!advance && stall_q != 16'hFFFF)  stall_q  <= stall_q + 16'd1;
            if (bubble_ev && bubble_q != 16'hFFFF) bubble_q <= bubble_q + 16'd1;
            if (flush_ev && flush_q != 16'hFFFF)   flush_q  <= flush_q + 16'd1;
        end
    end

    assign bus.stall_count  = stall_q;
    assign bus.bubble_count = bubble_q;
    assign bus.flush_count  = flush_q;
endmodule

// File: tb/tb_pipeline_controller.sv
// Directed self-checking bench for pipeline_controller.
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_pipeline_controller;
    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   passed = 0;
    int   failed = 0;

    pipeline_controller_if bus ();

    pipeline_controller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [3:0] loads();
        return {bus.load_if_id, bus.load_id_ex, bus.load_ex_mem, bus.load_mem_wb};
    endfunction

    function automatic logic [2:0] flushes();
        return {bus.flush_if_id, bus.flush_id_ex, bus.flush_ex_mem};
    endfunction

    initial begin
        reset_n              = 1'b0;
        bus.imem_resp        = 1'b0;
        bus.mem_access       = 1'b0;
        bus.mem_indirect     = 1'b0;
        bus.dmem_resp        = 1'b0;
        bus.br_taken         = 1'b0;
        bus.ex_load_inst     = 1'b0;
        bus.ex_regfile_write = 1'b0;
        bus.ex_dest          = 3'd0;
        bus.id_uses_sr1      = 1'b0;
        bus.id_uses_sr2      = 1'b0;
        bus.id_sr1           = 3'd0;
        bus.id_sr2           = 3'd0;
        bus.perf_clear       = 1'b0;

        // Reset: outputs quiet even with responses present
        tick();
        bus.imem_resp  = 1'b1;
        bus.mem_access = 1'b1;
        bus.dmem_resp  = 1'b1;
        settle();
        check("rst_req", {14'd0, bus.imem_req, bus.dmem_req}, 16'h0);
        check("rst_latch", {14'd0, bus.load_ir, bus.load_mdr}, 16'h0);
        check("rst_loads", {11'd0, loads(), bus.load_pc}, 16'h0);
        check("rst_stall", bus.stall_count, 16'h0);
        tick();
        bus.imem_resp  = 1'b0;
        bus.mem_access = 1'b0;
        bus.dmem_resp  = 1'b0;
        reset_n = 1'b1;

        // T1: cycle 1 no response, cycle 2 imem_resp
        settle();
        check("t1_c1_req", {15'd0, bus.imem_req}, 16'h1);
        check("t1_c1_loads", {11'd0, loads(), bus.load_pc}, 16'h0);
        tick();
        bus.imem_resp = 1'b1;
        settle();
        check("t1_c2_req", {15'd0, bus.imem_req}, 16'h1);
        check("t1_c2_loads", {11'd0, loads(), bus.load_pc}, 16'h1F);
        check("t1_c2_ir", {15'd0, bus.load_ir}, 16'h1);
        tick();
        check("t1_stall", bus.stall_count, 16'd1);

        // T2: load-use hazard on SR2
        bus.ex_load_inst     = 1'b1;
        bus.ex_regfile_write = 1'b1;
        bus.ex_dest          = 3'd3;
        bus.id_uses_sr2      = 1'b1;
        bus.id_sr2           = 3'd3;
        settle();
        check("t2_bubble0", bus.bubble_count, 16'd0);
        check("t2_pc", {15'd0, bus.load_pc}, 16'h0);
        check("t2_loads", {12'd0, loads()}, 16'h7);
        check("t2_flush", {13'd0, flushes()}, 16'h2);
        tick();
        check("t2_bubble1", bus.bubble_count, 16'd1);
        bus.imem_resp        = 1'b0;
        bus.ex_load_inst     = 1'b0;
        bus.id_uses_sr2      = 1'b0;
        settle();
        check("t2_held_req", {15'd0, bus.imem_req}, 16'h0);
        check("t2_resume", {11'd0, loads(), bus.load_pc}, 16'h1F);
        tick();
        check("t2_bubble_hold", bus.bubble_count, 16'd1);
        check("t2_refetch", {15'd0, bus.imem_req}, 16'h1);

        // T3: LDI, dmem_resp in cycles 3 and 6
        bus.mem_access   = 1'b1;
        bus.mem_indirect = 1'b1;
        bus.imem_resp    = 1'b1;
        settle();
        check("t3_c1", {11'd0, loads(), bus.dmem_req}, 16'h1);
        tick();
        bus.imem_resp = 1'b0;
        settle();
        check("t3_c2", {12'd0, bus.imem_req, bus.dmem_req, bus.load_if_id,
                        bus.indirect_sel}, 16'h4);
        tick();
        bus.dmem_resp = 1'b1;
        settle();
        check("t3_c3", {12'd0, bus.load_mdr, bus.indirect_sel, bus.load_if_id,
                        bus.load_mem_wb}, 16'h8);
        tick();
        bus.dmem_resp = 1'b0;
        settle();
        check("t3_c4", {12'd0, bus.indirect_sel, bus.dmem_req, bus.load_mdr,
                        bus.load_mem_wb}, 16'hC);
        tick();
        settle();
        check("t3_c5", {13'd0, bus.indirect_sel, bus.dmem_req,
                        bus.load_mem_wb}, 16'h6);
        tick();
        bus.dmem_resp = 1'b1;
        settle();
        check("t3_c6", {13'd0, bus.load_mdr, bus.indirect_sel, bus.load_pc},
              16'h7);
        check("t3_c6_loads", {12'd0, loads()}, 16'hF);
        tick();
        bus.dmem_resp    = 1'b0;
        bus.mem_access   = 1'b0;
        bus.mem_indirect = 1'b0;
        settle();
        check("t3_run", {15'd0, bus.indirect_sel}, 16'h0);
        check("t3_stall", bus.stall_count, 16'd6);

        // T4: early dmem_resp in cycle 2, imem_resp in cycle 5
        bus.mem_access = 1'b1;
        settle();
        check("t4_c1", {14'd0, bus.dmem_req, bus.load_if_id}, 16'h2);
        tick();
        bus.dmem_resp = 1'b1;
        settle();
        check("t4_c2", {14'd0, bus.load_mdr, bus.load_if_id}, 16'h2);
        tick();
        bus.dmem_resp = 1'b0;
        settle();
        check("t4_c3", {13'd0, bus.dmem_req, bus.load_mdr, bus.imem_req}, 16'h1);
        tick();
        settle();
        check("t4_c4", {13'd0, bus.dmem_req, bus.load_mdr, bus.load_if_id},
              16'h0);
        tick();
        bus.imem_resp = 1'b1;
        settle();
        check("t4_c5", {12'd0, bus.dmem_req, bus.load_mdr, bus.load_ir,
                        bus.load_if_id}, 16'h3);
        tick();
        bus.imem_resp = 1'b0;
        settle();
        check("t4_stall", bus.stall_count, 16'd10);
        check("t4_rereq", {15'd0, bus.dmem_req}, 16'h1);

        // T5: branch beats hazard; both responses in same cycle
        bus.imem_resp        = 1'b1;
        bus.dmem_resp        = 1'b1;
        bus.br_taken         = 1'b1;
        bus.ex_load_inst     = 1'b1;
        bus.ex_regfile_write = 1'b1;
        bus.ex_dest          = 3'd5;
        bus.id_uses_sr1      = 1'b1;
        bus.id_sr1           = 3'd5;
        settle();
        check("t5_pc", {14'd0, bus.load_pc, bus.pc_sel}, 16'h3);
        check("t5_flush", {13'd0, flushes()}, 16'h7);
        check("t5_loads", {12'd0, loads()}, 16'hF);
        check("t5_both", {14'd0, bus.load_ir, bus.load_mdr}, 16'h3);
        tick();
        check("t5_fcount", bus.flush_count, 16'd1);
        check("t5_bcount", bus.bubble_count, 16'd1);
        bus.imem_resp    = 1'b0;
        bus.dmem_resp    = 1'b0;
        bus.br_taken     = 1'b0;
        bus.ex_load_inst = 1'b0;
        bus.mem_access   = 1'b0;

        // T6: saturate stall counter, then clear
        repeat (70000) tick();
        check("t6_sat", bus.stall_count, 16'hFFFF);
        bus.perf_clear = 1'b1;
        settle();
        check("t6_clr_cycle", bus.stall_count, 16'hFFFF);
        tick();
        bus.perf_clear = 1'b0;
        check("t6_cleared", {bus.stall_count | bus.bubble_count
                             | bus.flush_count}, 16'h0);
        tick();
        check("t6_restart", bus.stall_count, 16'd1);

        // T7: reset mid-access abandons latched fetch
        bus.mem_access = 1'b1;
        bus.imem_resp  = 1'b1;
        tick();
        bus.imem_resp = 1'b0;
        settle();
        check("t7_done", {15'd0, bus.imem_req}, 16'h0);
        reset_n = 1'b0;
        settle();
        check("t7_rst", {14'd0, bus.imem_req, bus.dmem_req}, 16'h0);
        tick();
        reset_n = 1'b1;
        bus.mem_access = 1'b0;
        settle();
        check("t7_rel", {15'd0, bus.imem_req}, 16'h1);
        check("t7_cnt", bus.stall_count, 16'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
